// File: rtl/decoder_seq_n_if.sv
// Request/response bundle for decoder_seq_n.
// The master issues decode requests and the slave returns the registered decode.
interface decoder_seq_n_if #(
  parameter int N = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     addr;
  logic             en;
  logic [1:0]       mode;
  logic [2**N-1:0]  out;
  logic             out_valid;
  logic             busy;
  logic [N-1:0]     scan_idx;

  modport master (
    output in_valid, addr, en, mode,
    input  in_ready, out, out_valid, busy, scan_idx
  );

  modport slave (
    input  in_valid, addr, en, mode,
    output in_ready, out, out_valid, busy, scan_idx
  );
endinterface

// File: rtl/decoder_seq_n.sv
// Registered N-to-2^N one-hot write-enable decoder.
// Supports single-cycle pulse, latched hold and walking-one scan, with an optional hardwired-zero index.
module decoder_seq_n #(
  parameter int N        = 3,
  parameter int SCAN_LEN = 8,
  parameter int MASK_EN  = 0,
  parameter int MASK_IDX = 2**N-1
) (
  input logic            clk,
  input logic            reset,
  decoder_seq_n_if.slave bus
);

  localparam int W  = 2**N;
  localparam int LW = $clog2(SCAN_LEN + 1);

  localparam logic [1:0]    MODE_HOLD = 2'd1;
  localparam logic [1:0]    MODE_SCAN = 2'd2;
  localparam logic [LW-1:0] LEN_LAST  = LW'(SCAN_LEN);
  localparam logic [W-1:0]  KEEP_MASK = (MASK_EN != 0) ? ~(W'(1) << MASK_IDX) : '1;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD,
    SCAN
  } state_e;

  state_e        state, state_nx;
  logic [W-1:0]  out_q, out_nx;
  logic          valid_q, valid_nx;
  logic [N-1:0]  idx_q, idx_nx;
  logic [LW-1:0] len_q, len_nx;
  logic          scan_en_q, scan_en_nx;
  logic          accept;

  // The masked index is stripped here so no path can ever drive it high.
  function automatic logic [W-1:0] decode(input logic [N-1:0] idx, input logic enable);
    return enable ? ((W'(1) << idx) & KEEP_MASK) : '0;
  endfunction

  assign bus.in_ready  = (state != SCAN);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state == SCAN);
  assign bus.scan_idx  = idx_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_nx   = state;
    out_nx     = out_q;
    valid_nx   = valid_q;
    idx_nx     = idx_q;
    len_nx     = len_q;
    scan_en_nx = scan_en_q;

    if (state == SCAN) begin
      // len_q counts scan cycles already driven, including the one on the bus now.
      if (len_q == LEN_LAST) begin
        state_nx = IDLE;
        out_nx   = '0;
        valid_nx = 1'b0;
      end else begin
        idx_nx = idx_q + N'(1);
        len_nx = len_q + LW'(1);
        out_nx = decode(idx_q + N'(1), scan_en_q);
      end
    end else if (accept) begin
      valid_nx = 1'b1;
      out_nx   = decode(bus.addr, bus.en);
      case (bus.mode)
        MODE_HOLD: state_nx = HOLD;
        MODE_SCAN: begin
          state_nx   = SCAN;
          idx_nx     = bus.addr;
          len_nx     = LW'(1);
          scan_en_nx = bus.en;
        end
        default:   state_nx = PULSE;
      endcase
    end else if (state == PULSE) begin
      state_nx = IDLE;
      out_nx   = '0;
      valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      len_q     <= '0;
      scan_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state     <= state_nx;
      out_q     <= out_nx;
      valid_q   <= valid_nx;
      idx_q     <= idx_nx;
      len_q     <= len_nx;
      scan_en_q <= scan_en_nx;
    end
  end

  a_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(out_q));

  if (MASK_EN != 0) begin : g_mask_chk
    a_mask_low: assert property (@(posedge clk) disable iff (reset) out_q[MASK_IDX] == 1'b0);
  end

endmodule

// File: doc/decoder_seq_n.md
Name: decoder_seq_n

Overview:
Parametrised, registered N-to-2^N one-hot decoder. It is the next generation of the team's enabled combinational decoders and is used as the write-enable generator in front of register-file arrays. It adds a valid/ready request interface, a registered output, and three output modes: single-cycle pulse, latched hold, and a walking-one scan. An optional masked index always decodes to zero, for a hardwired zero register.

Parameters:
N, 3, address width; the output is 2**N bits wide (legal range 1..6).
SCAN_LEN, 8, number of cycles a scan asserts outputs (legal range 1..2**N; 2**N means a full sweep).
MASK_EN, 0, 1 = force output bit MASK_IDX to 0 at all times.
MASK_IDX, 2**N-1, index that is forced low when MASK_EN=1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
addr  input  N  index to decode; start index in scan mode
en  input  1  request enable; 0 = decode to all-zero
mode  input  2  0 = PULSE, 1 = HOLD, 2 = SCAN, 3 = reserved (behaves as PULSE)
out  output  2**N  registered one-hot (or zero) decode
out_valid  output  1  out carries the result of an accepted request
busy  output  1  scan in progress
scan_idx  output  N  index currently driven during a scan

Behaviour:
- One clock domain. reset asserted at any time, including mid-scan, immediately forces: out=0, out_valid=0, busy=0, scan_idx=0, state=IDLE. in_ready=1 whenever state!=SCAN, so in_ready reads 1 during reset.
- Accept occurs on a clk edge where in_valid && in_ready. addr, en and mode are sampled at accept only.
- Latency: out/out_valid update on the edge of the accept itself, so they are visible the cycle after in_valid && in_ready is seen.
- States: IDLE, PULSE, HOLD, SCAN.
- IDLE: out=0, out_valid=0.
  - Accept with mode 0/3 -> PULSE.
  - Accept with mode 1 -> HOLD.
  - Accept with mode 2 -> SCAN.
- PULSE: out=en ? onehot(addr) : 0 and out_valid=1, for exactly one cycle.
  - Next edge: back-to-back accept -> new state per that request's mode; otherwise -> IDLE.
  - in_ready=1.
- HOLD: out and out_valid=1 held indefinitely.
  - Any new accept replaces them per the new mode; a PULSE request ends the hold after its one cycle.
  - in_ready=1.
- SCAN: busy=1, in_ready=0 (in_valid ignored).
  - If en=1: cycle k (k=0..SCAN_LEN-1) drives out=onehot(addr+k mod 2**N), scan_idx=addr+k mod 2**N, out_valid=1. Wrap 2**N-1 -> 0 is required.
  - If en=0: out=0 for all SCAN_LEN cycles, out_valid=1, scan_idx still advances.
  - After SCAN_LEN cycles: -> IDLE, out=0, out_valid=0, busy=0. in_ready returns to 1 on that same edge, so the earliest next accept is the first IDLE cycle.
  - scan_idx holds its last value outside SCAN.
- Mask: when MASK_EN=1, out[MASK_IDX] is 0 in every state.
  - A pulse or hold request to MASK_IDX yields out=0 with out_valid=1.
  - A scan still spends one cycle on MASK_IDX, with out=0 during that cycle.
- Invariant: at most one bit of out is high in any cycle (popcount(out)<=1).
- addr width arithmetic is modulo 2**N; the scan counter must be N bits plus a separate length counter of ceil(log2(SCAN_LEN+1)) bits.

Test Plan:
- N=3, reset mid-operation: assert reset during the 3rd scan cycle -> out=0, busy=0, in_ready=1 within the same cycle (async); after release, IDLE with out=0.
- Pulse sweep: accept addr=0..7, en=1, mode=0 back-to-back -> out=8'h01,8'h02,...,8'h80 on consecutive cycles, each for one cycle, out_valid=1 throughout. Then idle -> out=0, out_valid=0.
- Enable off: mode=0, addr=5, en=0 -> out=8'h00, out_valid=1 for one cycle. mode=1, addr=5, en=1 -> out=8'h20 held for 10 idle cycles until a new accept with addr=2 -> out=8'h04.
- Scan with wrap: N=3, SCAN_LEN=8, accept addr=6, en=1, mode=2 -> out=8'h40,80,01,02,04,08,10,20 and scan_idx=6,7,0..5. in_ready=0 for 8 cycles; in_valid held high during the scan is ignored and accepted only on the first IDLE cycle.
- Mask: MASK_EN=1, MASK_IDX=7. Pulse addr=7 -> out=8'h00, out_valid=1. Scan from addr=5, SCAN_LEN=4 -> out=8'h20, 8'h40, 8'h00, 8'h01.
- Random: 2000 random requests across modes 0-3 -> popcount(out)<=1 every cycle, and out matches a cycle-accurate reference model.
